uart_mem_bridge: RTL and testbench

UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

---
 rtl/uart_mem_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_bridge
// Purpose  : Byte-oriented command bridge from a UART receiver/transmitter
//            pair to a simple 32-bit word memory port.
//            Commands: 'W' a0 a1 a2 a3 d0 d1 d2 d3 -> write, reply 'K'
//                      'R' a0 a1 a2 a3             -> read, reply 4 data bytes
//            Multi-byte fields are little-endian. An unknown opcode replies
//            '?'. A stalled command is dropped after TIMEOUT_CYCLES idle
//            cycles. Bytes arriving while a command executes are dropped.
// Ports    : clk, rst (async, active-low)
//            rx_byte/rx_valid              - received byte stream
//            tx_byte/tx_en/tx_ready        - transmit byte stream
//            mem_addr/mem_wdata/mem_we/mem_re/mem_rdata/mem_rvalid - memory
//            busy        - any state other than IDLE
//            proto_error - one-cycle pulse on a protocol fault
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_bridge #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_en,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy,
  output logic        proto_error
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    MEM_WRITE = 3'd3,
    MEM_READ  = 3'd4,
    WAIT_READ = 3'd5,
    SEND      = 3'd6,
    SEND_WAIT = 3'd7
  } state_t;

  state_t      state_q;
  logic        is_write_q;
  logic [1:0]  cnt_q;        // byte index within the current 4-byte field
  logic [31:0] gap_q;        // idle cycles since the last accepted byte
  logic [31:0] resp_q;       // pending response bytes, next byte in [7:0]
  logic [2:0]  resp_left_q;  // response bytes not yet handed to tx
  logic        seen_low_q;   // tx_ready seen low since the last tx_en
  logic [7:0]  tx_byte_q;
  logic        tx_en_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic        perr_q;

  logic        w_exec_state;
  assign w_exec_state = (state_q == MEM_WRITE) || (state_q == MEM_READ) ||
                        (state_q == WAIT_READ) || (state_q == SEND) ||
                        (state_q == SEND_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      cnt_q       <= 2'd0;
      gap_q       <= 32'd0;
      resp_q      <= 32'd0;
      resp_left_q <= 3'd0;
      seen_low_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_en_q     <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      tx_en_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      perr_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if ((rx_byte == OP_WRITE) || (rx_byte == OP_READ)) begin
              is_write_q <= (rx_byte == OP_WRITE);
              cnt_q      <= 2'd0;
              gap_q      <= 32'd0;
              state_q    <= GET_ADDR;
            end else begin
              resp_q      <= {24'h0, RESP_ERR};
              resp_left_q <= 3'd1;
              perr_q      <= 1'b1;
              state_q     <= SEND;
            end
          end
        end

        GET_ADDR, GET_DATA: begin
          // An arriving byte wins over a timeout in the same cycle.
          if (rx_valid) begin
            gap_q <= 32'd0;
            cnt_q <= cnt_q + 2'd1;
            if (state_q == GET_ADDR) begin
              mem_addr_q[{cnt_q, 3'b000} +: 8] <= rx_byte;
            end else begin
              mem_wdata_q[{cnt_q, 3'b000} +: 8] <= rx_byte;
            end
            if (cnt_q == 2'd3) begin
              // Strobes are raised on entry so they coincide with the
              // MEM_WRITE / MEM_READ state cycle.
              if (state_q == GET_DATA) begin
                mem_we_q <= 1'b1;
                state_q  <= MEM_WRITE;
              end else if (is_write_q) begin
                state_q  <= GET_DATA;
              end else begin
                mem_re_q <= 1'b1;
                state_q  <= MEM_READ;
              end
            end
          end else if ((gap_q + 32'd1) == TIMEOUT_CYCLES) begin
            // The counter would reach the limit on this edge.
            perr_q  <= 1'b1;
            gap_q   <= 32'd0;
            cnt_q   <= 2'd0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end

        MEM_WRITE: begin
          resp_q      <= {24'h0, RESP_OK};
          resp_left_q <= 3'd1;
          state_q     <= SEND;
        end

        MEM_READ: begin
          state_q <= WAIT_READ;
        end

        WAIT_READ: begin
          if (mem_rvalid) begin
            resp_q      <= mem_rdata;
            resp_left_q <= 3'd4;
            state_q     <= SEND;
          end
        end

        SEND: begin
          if (tx_ready) begin
            tx_byte_q   <= resp_q[7:0];
            tx_en_q     <= 1'b1;
            resp_q      <= {8'h00, resp_q[31:8]};
            resp_left_q <= resp_left_q - 3'd1;
            seen_low_q  <= 1'b0;
            state_q     <= SEND_WAIT;
          end
        end

        SEND_WAIT: begin
          // Wait for a full busy/idle handshake of the transmitter.
          if (!tx_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            state_q <= (resp_left_q != 3'd0) ? SEND : IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

      if (rx_valid && w_exec_state) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign tx_byte     = tx_byte_q;
  assign tx_en       = tx_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign busy        = (state_q != IDLE);
  assign proto_error = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_bridge
// Purpose  : Self-checking bench for uart_mem_bridge. A transaction-level
//            model predicts memory strobes, transmitted bytes and protocol
//            error pulses; a single monitor compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_en;
  logic        tx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        proto_error;

  always #5 clk = ~clk;

  uart_mem_bridge #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst(rst),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_en(tx_en), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .proto_error(proto_error)
  );

  // ---------------- bookkeeping / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exp_perr = 0;
  int obs_perr = 0;
  int last_perr_cyc = -1;
  int n_we = 0;
  int n_tx = 0;
  int rd_delay_fixed = 0;

  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] exp_ra[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] dev_mem[logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_tx_en;
    prev_tx_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_we) begin
          n_we++;
          chk("we_expected", 32'(exp_wa.size() != 0), 32'd1);
          if (exp_wa.size() != 0) begin
            chk("wr_addr", mem_addr, exp_wa.pop_front());
            chk("wr_data", mem_wdata, exp_wd.pop_front());
          end
        end
        if (mem_re) begin
          chk("re_expected", 32'(exp_ra.size() != 0), 32'd1);
          if (exp_ra.size() != 0) chk("rd_addr", mem_addr, exp_ra.pop_front());
        end
        if (tx_en) begin
          n_tx++;
          chk("tx_ready_at_tx_en", {31'b0, tx_ready}, 32'd1);
          chk("tx_en_back_to_back", {31'b0, prev_tx_en}, 32'd0);
          chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
          if (exp_tx.size() != 0) chk("tx_byte", {24'h0, tx_byte}, {24'h0, exp_tx.pop_front()});
        end
        if (proto_error) begin
          obs_perr++;
          last_perr_cyc = cyc;
        end
      end
      prev_tx_en = tx_en;
    end
  end

  // ---------------- UART transmitter model ----------------
  initial begin
    tx_ready = 1'b1;
    forever begin
      int n;
      @(negedge clk);
      if (tx_en) begin
        n = $urandom_range(1, 4);
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // ---------------- memory model ----------------
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      logic [31:0] a;
      int d;
      @(negedge clk);
      if (mem_we && rst) dev_mem[mem_addr] = mem_wdata;
      if (mem_re && rst) begin
        a = mem_addr;
        d = (rd_delay_fixed > 0) ? rd_delay_fixed : $urandom_range(1, 5);
        repeat (d) @(posedge clk);
        #1 mem_rvalid = 1'b1;
        mem_rdata = dev_mem.exists(a) ? dev_mem[a] : dflt(a);
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int rg();
    return $urandom_range(0, 3);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    acc_cyc  = cyc;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rg());
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_idle_in_time"}, 32'(t < 400), 32'd1);
    chk({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    chk({name, "_wr_left"}, 32'(exp_wa.size()), 32'd0);
    chk({name, "_rd_left"}, 32'(exp_ra.size()), 32'd0);
    chk({name, "_perr_count"}, 32'(obs_perr), 32'(exp_perr));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
    exp_tx.push_back(8'h4B);
    model_mem[a] = d;
    send_byte(8'h57, rg());
    send_word(a);
    send_word(d);
    wait_idle("write");
    chk("wr_addr_hold", mem_addr, a);
    chk("wr_data_hold", mem_wdata, d);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] v;
    v = model_rd(a);
    exp_ra.push_back(a);
    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
    send_byte(8'h52, rg());
    send_word(a);
    wait_idle("read");
    chk("rd_addr_hold", mem_addr, a);
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_perr++;
    exp_tx.push_back(8'h3F);
    send_byte(b, rg());
    wait_idle("bad_op");
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tx_byte"}, {24'h0, tx_byte}, 32'd0);
    chk({name, "_tx_en"}, {31'b0, tx_en}, 32'd0);
    chk({name, "_mem_addr"}, mem_addr, 32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({name, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({name, "_mem_re"}, {31'b0, mem_re}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_proto_error"}, {31'b0, proto_error}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int we0;
    int tx0;
    int t;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Directed write: 57 10 00 00 00 EF BE AD DE
    we0 = n_we; tx0 = n_tx;
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    chk("write_we_pulses", 32'(n_we - we0), 32'd1);
    chk("write_tx_pulses", 32'(n_tx - tx0), 32'd1);

    // Directed read: rvalid 3 cycles after mem_re, tx 78 56 34 12
    dev_mem[32'h4] = 32'h1234_5678;
    model_mem[32'h4] = 32'h1234_5678;
    exp_ra.push_back(32'h4);
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    rd_delay_fixed = 3;
    tx0 = n_tx;
    send_byte(8'h52, 0);
    send_word(32'h4);
    wait_idle("dir_read");
    rd_delay_fixed = 0;
    chk("read_tx_pulses", 32'(n_tx - tx0), 32'd4);

    // Bad opcode 'A'
    do_bad(8'h41);
    chk("bad_busy_low", {31'b0, busy}, 32'd0);

    // Timeout: 57 01 then silence
    we0 = n_we; tx0 = n_tx;
    exp_perr++;
    send_byte(8'h57, 0);
    send_byte(8'h01, 0);
    t = 0;
    while (obs_perr != exp_perr && t < 150) begin
      @(posedge clk); #1;
      t++;
    end
    chk("timeout_seen", 32'(obs_perr), 32'(exp_perr));
    chk("timeout_cycle", 32'(last_perr_cyc), 32'(acc_cyc + 100));
    @(posedge clk); #1;
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    chk("timeout_no_we", 32'(n_we - we0), 32'd0);
    chk("timeout_no_tx", 32'(n_tx - tx0), 32'd0);

    // Byte arriving exactly on the timeout cycle is accepted
    exp_wa.push_back(32'h0000_0003);
    exp_wd.push_back(32'hA5C3_0F1E);
    exp_tx.push_back(8'h4B);
    model_mem[32'h3] = 32'hA5C3_0F1E;
    send_byte(8'h57, 0);
    send_byte(8'h03, 98);
    send_byte(8'h00, 97);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_word(32'hA5C3_0F1E);
    wait_idle("timeout_edge");

    // Overrun during SEND_WAIT
    exp_perr++;
    exp_ra.push_back(32'h4);
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    send_byte(8'h52, 0);
    send_word(32'h4);
    t = 0;
    while (!tx_en && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("overrun_tx_seen", 32'(t < 100), 32'd1);
    rx_byte = 8'h55; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    wait_idle("overrun");

    // Reset during WAIT_READ
    exp_ra.push_back(32'h8);
    rd_delay_fixed = 20;
    send_byte(8'h52, 0);
    send_word(32'h8);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (25) @(posedge clk); #1;
    rd_delay_fixed = 0;
    chk("mid_reset_busy", {31'b0, busy}, 32'd0);
    do_read(32'h8);

    // Randomised command mix
    for (int k = 0; k < 40; k++) begin
      int sel;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_bad(b);
      end else if (sel < 5) begin
        do_write(32'($urandom_range(0, 7)), 32'($urandom));
      end else begin
        do_read(32'($urandom_range(0, 7)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
